// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DBIT_DEF       = 8;
  localparam int SB_TICK_DEF    = 16;

  // Smallest counter width able to hold 0..max_count-1 (never narrower than one bit).
  function automatic int cnt_width(input int max_count);
    return (max_count > 2) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus a falling-edge detector.
// All flops reset to 1 so the idle-high line never looks like a start edge out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rx_s    = sync2;
  assign rx_fall = prev & ~sync2;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversampled start/data/stop framing, LSB-first deserialization, one-clk done strobe.
// Optional parity bit after the data bits when UART_RX_PARITY_EN is defined.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DBIT       = DBIT_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int SB_TICK    = SB_TICK_DEF,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            framing_err,
  output logic            parity_err
);

`ifdef UART_RX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  localparam int SW = cnt_width((OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK);
  localparam int NW = cnt_width(DBIT);

  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT     = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP    = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
  localparam logic          PAR_SENSE = (PARITY_ODD != 0);

  logic rx_s;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  rx_state_t       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            par_bit_q, par_bit_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            fe_q, fe_d;
  logic            pe_q, pe_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      par_bit_q <= 1'b0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      par_bit_q <= par_bit_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
    end
  end

  // Every state counts s_tick pulses only; the IDLE edge check ignores s_tick so a coincident tick is dropped.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    par_bit_d = par_bit_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    fe_d      = fe_q;
    pe_d      = pe_q;

    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = DBIT'({rx_s, b_q} >> 1);
            if (n_q == N_LAST) begin
              state_d = PARITY_EN ? PARITY : STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d       = '0;
            par_bit_d = rx_s;
            state_d   = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            dout_d  = b_q;
            fe_d    = ~rx_s;
            pe_d    = PARITY_EN & (^b_q ^ par_bit_q ^ PAR_SENSE);
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign framing_err  = fe_q;
  assign parity_err   = pe_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: framing, glitch rejection, errors, back-to-back, mid-frame reset.
// Parity cases run only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;
  import uart_pkg::*;

  // A short tick period keeps run time small; the receiver only ever counts ticks.
  localparam int TICK_DIV   = 8;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLK    = OVERSAMPLE * TICK_DIV;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       framing_err;
  logic       parity_err;

  int checks = 0;
  int errors = 0;
  int strobe_count = 0;
  int off_tick_strobes = 0;
  int wide_strobes = 0;
  int tick_phase = 0;
  logic prev_done = 1'b0;
  logic [7:0] dout_log[$];
  logic       fe_log[$];
  logic       pe_log[$];

  uart_rx_deserializer #(
    .DBIT       (8),
    .OVERSAMPLE (OVERSAMPLE),
    .SB_TICK    (16),
    .PARITY_ODD (0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .framing_err  (framing_err),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  // Strobe monitor runs before the tick update, so s_tick still shows what the last posedge sampled.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      strobe_count++;
      if (!s_tick) off_tick_strobes++;
      if (prev_done) wide_strobes++;
      dout_log.push_back(dout);
      fe_log.push_back(framing_err);
      pe_log.push_back(parity_err);
    end
    prev_done = rx_done_tick;
    if (tick_phase == TICK_DIV - 1) begin
      s_tick = 1'b1;
      tick_phase = 0;
    end else begin
      s_tick = 1'b0;
      tick_phase++;
    end
  end

  function automatic logic goodParity(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveBit(input logic v);
    rx = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic idleBits(input int nbits);
    rx = 1'b1;
    repeat (nbits * BIT_CLK) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_val, input logic par_val);
    logic unused_par;
    unused_par = par_val;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
`ifdef UART_RX_PARITY_EN
    driveBit(unused_par);
`endif
    driveBit(stop_val);
  endtask

  initial begin
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reset_dout", 32'(dout), 32'h0);
    checkOutput("reset_done", 32'(rx_done_tick), 32'h0);
    checkOutput("reset_fe", 32'(framing_err), 32'h0);
    checkOutput("reset_pe", 32'(parity_err), 32'h0);
    checkOutput("reset_state", 32'(dut.state_q), 32'(IDLE));
    reset_n = 1'b1;
    idleBits(2);

    $display("[TB] step 1: frame 0xA5");
    applyStimulus(8'hA5, 1'b1, goodParity(8'hA5));
    idleBits(1);
    checkOutput("a5_strobes", 32'(strobe_count), 32'd1);
    checkOutput("a5_dout", 32'(dout), 32'hA5);
    checkOutput("a5_fe", 32'(framing_err), 32'h0);
    checkOutput("a5_pe", 32'(parity_err), 32'h0);
    checkOutput("a5_strobe_on_tick", 32'(off_tick_strobes), 32'd0);
    checkOutput("a5_strobe_width", 32'(wide_strobes), 32'd0);

    $display("[TB] step 2: 4-tick glitch then 0x3C");
    rx = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    idleBits(2);
    checkOutput("glitch_no_strobe", 32'(strobe_count), 32'd1);
    checkOutput("glitch_idle", 32'(dut.state_q), 32'(IDLE));
    applyStimulus(8'h3C, 1'b1, goodParity(8'h3C));
    idleBits(1);
    checkOutput("post_glitch_strobes", 32'(strobe_count), 32'd2);
    checkOutput("post_glitch_dout", 32'(dout), 32'h3C);
    checkOutput("post_glitch_fe", 32'(framing_err), 32'h0);

    $display("[TB] step 3: 0x3C with low stop bit, line held low");
    applyStimulus(8'h3C, 1'b0, goodParity(8'h3C));
    checkOutput("ferr_strobes", 32'(strobe_count), 32'd3);
    checkOutput("ferr_dout", 32'(dout), 32'h3C);
    checkOutput("ferr_fe", 32'(framing_err), 32'h1);
    rx = 1'b0;
    repeat (3 * BIT_CLK) @(negedge clk);
    checkOutput("held_low_no_frame", 32'(strobe_count), 32'd3);
    checkOutput("held_low_idle", 32'(dut.state_q), 32'(IDLE));
    idleBits(2);
    checkOutput("released_no_frame", 32'(strobe_count), 32'd3);

    $display("[TB] step 4: back-to-back 0x00 0xFF 0x55");
    applyStimulus(8'h00, 1'b1, goodParity(8'h00));
    applyStimulus(8'hFF, 1'b1, goodParity(8'hFF));
    applyStimulus(8'h55, 1'b1, goodParity(8'h55));
    idleBits(1);
    checkOutput("b2b_strobes", 32'(strobe_count), 32'd6);
    if (dout_log.size() >= 6) begin
      checkOutput("b2b_dout0", 32'(dout_log[3]), 32'h00);
      checkOutput("b2b_dout1", 32'(dout_log[4]), 32'hFF);
      checkOutput("b2b_dout2", 32'(dout_log[5]), 32'h55);
      checkOutput("b2b_errs", 32'({fe_log[3], fe_log[4], fe_log[5], pe_log[3], pe_log[4], pe_log[5]}), 32'h0);
    end

    $display("[TB] step 5: reset during data bit 3 of 0x81");
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    driveBit(1'b0);
    rx = 1'b0;
    repeat (BIT_CLK / 2) @(negedge clk);
    reset_n = 1'b0;
    rx = 1'b1;
    #1;
    checkOutput("midreset_dout", 32'(dout), 32'h0);
    checkOutput("midreset_done", 32'(rx_done_tick), 32'h0);
    checkOutput("midreset_state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idleBits(2);
    checkOutput("midreset_no_strobe", 32'(strobe_count), 32'd6);
    applyStimulus(8'h5A, 1'b1, goodParity(8'h5A));
    idleBits(1);
    checkOutput("after_reset_strobes", 32'(strobe_count), 32'd7);
    checkOutput("after_reset_dout", 32'(dout), 32'h5A);

`ifdef UART_RX_PARITY_EN
    $display("[TB] step 6: parity on 0x07");
    applyStimulus(8'h07, 1'b1, 1'b0);
    idleBits(1);
    checkOutput("par_bad_strobes", 32'(strobe_count), 32'd8);
    checkOutput("par_bad_pe", 32'(parity_err), 32'h1);
    applyStimulus(8'h07, 1'b1, 1'b1);
    idleBits(1);
    checkOutput("par_good_dout", 32'(dout), 32'h07);
    checkOutput("par_good_pe", 32'(parity_err), 32'h0);
`endif

    checkOutput("all_strobes_on_tick", 32'(off_tick_strobes), 32'd0);
    checkOutput("all_strobes_one_clk", 32'(wide_strobes), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
